// File: rtl/vc_idx_fifo.sv
// vc_idx_fifo: NUM_CH independent circular FIFOs of buffer-slot indices, one per virtual channel
// Ports: clk/rst (sync, active-high); wr_en/wr_ch/wr_data push; rd_en/rd_ch pop;
// rd_data/rd_valid registered pop result; full/empty/count per channel; sticky err_ovf/err_udf/err_ch.
module vc_idx_fifo #(
    parameter int NUM_CH = 4,
    parameter int CH_SZ  = 2,
    parameter int DEPTH  = 3,
    parameter int PTR_SZ = 2,
    parameter int WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [CH_SZ-1:0]               wr_ch,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    input  logic [CH_SZ-1:0]               rd_ch,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           rd_valid,
    output logic [NUM_CH-1:0]              full,
    output logic [NUM_CH-1:0]              empty,
    output logic [NUM_CH*(PTR_SZ+1)-1:0]   count,
    output logic                           err_ovf,
    output logic                           err_udf,
    output logic                           err_ch
);
    localparam logic [CH_SZ:0]    NCH  = (CH_SZ+1)'(NUM_CH);
    localparam logic [PTR_SZ:0]   DEP  = (PTR_SZ+1)'(DEPTH);
    localparam logic [PTR_SZ-1:0] LAST = PTR_SZ'(DEPTH - 1);
    logic [WIDTH-1:0]  mem [NUM_CH][DEPTH];
    logic [PTR_SZ-1:0] wptr_q [NUM_CH], wptr_d [NUM_CH];
    logic [PTR_SZ-1:0] rptr_q [NUM_CH], rptr_d [NUM_CH];
    logic [PTR_SZ:0]   cnt_q [NUM_CH], cnt_d [NUM_CH];
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_ovf_q, err_ovf_d, err_udf_q, err_udf_d, err_ch_q, err_ch_d;
    logic              wr_in, rd_in, pop_ok, push_ok;
    logic [NUM_CH-1:0] push_v, pop_v;
    always_comb begin
        wr_in      = {1'b0, wr_ch} < NCH;
        rd_in      = {1'b0, rd_ch} < NCH;
        pop_ok     = rd_en && rd_in && cnt_q[rd_ch] != '0;
        // a full channel still takes a push when it is popped in the same cycle
        push_ok    = wr_en && wr_in && (cnt_q[wr_ch] != DEP || (pop_ok && rd_ch == wr_ch));
        push_v     = '0;
        pop_v      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            push_v[i] = push_ok && wr_ch == CH_SZ'(i);
            pop_v[i]  = pop_ok && rd_ch == CH_SZ'(i);
            // explicit wrap since DEPTH need not be a power of two
            wptr_d[i] = push_v[i] ? (wptr_q[i] == LAST ? '0 : wptr_q[i] + 1'b1) : wptr_q[i];
            rptr_d[i] = pop_v[i] ? (rptr_q[i] == LAST ? '0 : rptr_q[i] + 1'b1) : rptr_q[i];
            cnt_d[i]  = (push_v[i] && !pop_v[i]) ? cnt_q[i] + 1'b1 :
                        (pop_v[i] && !push_v[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
        rd_valid_d = pop_ok;
        rd_data_d  = pop_ok ? mem[rd_ch][rptr_q[rd_ch]] : rd_data_q;
        err_ovf_d  = err_ovf_q || (wr_en && wr_in && !push_ok);
        err_udf_d  = err_udf_q || (rd_en && rd_in && !pop_ok);
        err_ch_d   = err_ch_q || (wr_en && !wr_in) || (rd_en && !rd_in);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            err_ch_q   <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            err_ch_q   <= err_ch_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ch][wptr_q[wr_ch]] <= wr_data;
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_out
        assign full[i]                             = cnt_q[i] == DEP;
        assign empty[i]                            = cnt_q[i] == '0;
        assign count[i*(PTR_SZ+1) +: (PTR_SZ+1)]   = cnt_q[i];
    end
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err_ovf  = err_ovf_q;
    assign err_udf  = err_udf_q;
    assign err_ch   = err_ch_q;
endmodule

// File: tb/tb_vc_idx_fifo.sv
// tb_vc_idx_fifo: checks a 4-channel and a 3-channel vc_idx_fifo against per-channel queue models
module tb_vc_idx_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [1:0]  wr_ch = '0, rd_ch = '0;
    logic [3:0]  wr_data = '0;
    logic [3:0]  rd_data4, full4, empty4, rd_data3;
    logic        rd_valid4, eo4, eu4, ec4, rd_valid3, eo3, eu3, ec3;
    logic [11:0] count4;
    logic [2:0]  full3, empty3;
    logic [8:0]  count3;
    logic [3:0]  o_rd_data [2];
    logic        o_rd_valid [2];
    logic [3:0]  o_full [2], o_empty [2];
    logic [11:0] o_count [2];
    logic [2:0]  o_err [2];
    logic [3:0]  q [2][4][$];
    logic [3:0]  m_rd_data [2];
    logic        m_rd_valid [2];
    logic [2:0]  m_err [2];
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    vc_idx_fifo dut4 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data4), .rd_valid(rd_valid4), .full(full4),
        .empty(empty4), .count(count4), .err_ovf(eo4), .err_udf(eu4), .err_ch(ec4));
    vc_idx_fifo #(.NUM_CH(3)) dut3 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data3), .rd_valid(rd_valid3), .full(full3),
        .empty(empty3), .count(count3), .err_ovf(eo3), .err_udf(eu3), .err_ch(ec3));

    assign o_rd_data[0]  = rd_data4;
    assign o_rd_data[1]  = rd_data3;
    assign o_rd_valid[0] = rd_valid4;
    assign o_rd_valid[1] = rd_valid3;
    assign o_full[0]     = full4;
    assign o_full[1]     = {1'b0, full3};
    assign o_empty[0]    = empty4;
    assign o_empty[1]    = {1'b0, empty3};
    assign o_count[0]    = count4;
    assign o_count[1]    = {3'b0, count3};
    assign o_err[0]      = {eo4, eu4, ec4};
    assign o_err[1]      = {eo3, eu3, ec3};

    function automatic int nch(int k);
        return k == 0 ? 4 : 3;
    endfunction

    function automatic logic [3:0] m_full(int k);
        logic [3:0] r = '0;
        for (int c = 0; c < nch(k); c++) r[c] = q[k][c].size() == 3;
        return r;
    endfunction

    function automatic logic [3:0] m_empty(int k);
        logic [3:0] r = '0;
        for (int c = 0; c < nch(k); c++) r[c] = q[k][c].size() == 0;
        return r;
    endfunction

    function automatic logic [11:0] m_count(int k);
        logic [11:0] r = '0;
        for (int c = 0; c < nch(k); c++) r[c*3 +: 3] = 3'(q[k][c].size());
        return r;
    endfunction

    // applies the FIFO rules to the queues using the inputs present at this edge
    task automatic model_edge();
        logic pop_ok, push_ok;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int c = 0; c < 4; c++) q[k][c].delete();
                m_rd_data[k]  = '0;
                m_rd_valid[k] = 1'b0;
                m_err[k]      = '0;
            end else begin
                pop_ok  = rd_en && rd_ch < nch(k) && q[k][rd_ch].size() > 0;
                push_ok = wr_en && wr_ch < nch(k) && (q[k][wr_ch].size() < 3 || (pop_ok && rd_ch == wr_ch));
                m_rd_valid[k] = pop_ok;
                if (pop_ok) m_rd_data[k] = q[k][rd_ch].pop_front();
                if (push_ok) q[k][wr_ch].push_back(wr_data);
                if (wr_en && wr_ch < nch(k) && !push_ok) m_err[k][2] = 1'b1;
                if (rd_en && rd_ch < nch(k) && !pop_ok) m_err[k][1] = 1'b1;
                if ((wr_en && wr_ch >= nch(k)) || (rd_en && rd_ch >= nch(k))) m_err[k][0] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic we, input logic [1:0] wc, input logic [3:0] wd, input logic re, input logic [1:0] rc);
        wr_en = we; wr_ch = wc; wr_data = wd; rd_en = re; rd_ch = rc;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1, 1, 4'h3, 1, 2);
        step(1, 2, 4'h5, 1, 1);
        rst = 1'b0;
        checks++; if (o_empty[0] !== 4'hf) begin failures++; $display("FAIL reset_empty got=%h exp=f", o_empty[0]); end
        checks++; if (o_full[0] !== 4'h0) begin failures++; $display("FAIL reset_full got=%h exp=0", o_full[0]); end
        checks++; if (o_count[0] !== 12'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", o_count[0]); end
        checks++; if (o_rd_valid[0] !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", o_rd_valid[0]); end
        checks++; if (o_rd_data[0] !== 4'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", o_rd_data[0]); end
        checks++; if (o_err[0] !== 3'b000) begin failures++; $display("FAIL reset_err got=%b exp=000", o_err[0]); end
        checks++; if (o_empty[1] !== 4'h7) begin failures++; $display("FAIL reset_empty3 got=%h exp=7", o_empty[1]); end
        checks++; if (o_err[1] !== 3'b000) begin failures++; $display("FAIL reset_err3 got=%b exp=000", o_err[1]); end
    endtask

    task automatic test_ordering();
        do_reset();
        step(1, 2, 4'h1, 0, 0);
        step(1, 2, 4'h2, 0, 0);
        step(1, 2, 4'h3, 0, 0);
        checks++; if (o_full[0][2] !== 1'b1) begin failures++; $display("FAIL order_full2 got=%b exp=1", o_full[0][2]); end
        checks++; if (o_count[0] !== 12'h0c0) begin failures++; $display("FAIL order_count got=%h exp=0c0", o_count[0]); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 2);
            checks++; if (o_rd_valid[0] !== 1'b1) begin failures++; $display("FAIL order_valid%0d got=%b exp=1", i, o_rd_valid[0]); end
            checks++; if (o_rd_data[0] !== 4'(i + 1)) begin failures++; $display("FAIL order_data%0d got=%h exp=%h", i, o_rd_data[0], 4'(i + 1)); end
            checks++; if (o_rd_data[1] !== 4'(i + 1)) begin failures++; $display("FAIL order_data3_%0d got=%h exp=%h", i, o_rd_data[1], 4'(i + 1)); end
        end
        step(0, 0, 0, 0, 0);
        checks++; if (o_rd_valid[0] !== 1'b0) begin failures++; $display("FAIL order_valid_idle got=%b exp=0", o_rd_valid[0]); end
        checks++; if (o_rd_data[0] !== 4'h3) begin failures++; $display("FAIL order_data_hold got=%h exp=3", o_rd_data[0]); end
        checks++; if (o_empty[0] !== 4'hf) begin failures++; $display("FAIL order_empty got=%h exp=f", o_empty[0]); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp [3] = '{4'hb, 4'hc, 4'he};
        do_reset();
        step(1, 1, 4'ha, 0, 0);
        step(1, 1, 4'hb, 0, 0);
        step(1, 1, 4'hc, 0, 0);
        step(1, 1, 4'hd, 0, 0);
        checks++; if (o_err[0] !== 3'b100) begin failures++; $display("FAIL ovf_err got=%b exp=100", o_err[0]); end
        checks++; if (o_count[0] !== 12'h018) begin failures++; $display("FAIL ovf_count got=%h exp=018", o_count[0]); end
        step(0, 0, 0, 1, 1);
        checks++; if (o_rd_data[0] !== 4'ha) begin failures++; $display("FAIL ovf_pop_a got=%h exp=a", o_rd_data[0]); end
        step(1, 1, 4'he, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1);
            checks++; if (o_rd_valid[0] !== 1'b1 || o_rd_data[0] !== exp[i]) begin failures++; $display("FAIL ovf_wrap%0d got=%b/%h exp=1/%h", i, o_rd_valid[0], o_rd_data[0], exp[i]); end
        end
    endtask

    task automatic test_full_simul();
        do_reset();
        step(1, 0, 4'h5, 0, 0);
        step(1, 0, 4'h6, 0, 0);
        step(1, 0, 4'h7, 0, 0);
        step(1, 0, 4'h8, 1, 0);
        checks++; if (o_rd_data[0] !== 4'h5) begin failures++; $display("FAIL fsim_data got=%h exp=5", o_rd_data[0]); end
        checks++; if (o_count[0] !== 12'h003) begin failures++; $display("FAIL fsim_count got=%h exp=003", o_count[0]); end
        checks++; if (o_err[0] !== 3'b000) begin failures++; $display("FAIL fsim_err got=%b exp=000", o_err[0]); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            checks++; if (o_rd_data[0] !== 4'(6 + i)) begin failures++; $display("FAIL fsim_pop%0d got=%h exp=%h", i, o_rd_data[0], 4'(6 + i)); end
        end
    endtask

    task automatic test_empty_simul();
        do_reset();
        step(1, 3, 4'h9, 1, 3);
        checks++; if (o_rd_valid[0] !== 1'b0) begin failures++; $display("FAIL esim_valid got=%b exp=0", o_rd_valid[0]); end
        checks++; if (o_err[0] !== 3'b010) begin failures++; $display("FAIL esim_err got=%b exp=010", o_err[0]); end
        checks++; if (o_count[0] !== 12'h200) begin failures++; $display("FAIL esim_count got=%h exp=200", o_count[0]); end
        checks++; if (o_err[1] !== 3'b001) begin failures++; $display("FAIL esim_err3 got=%b exp=001", o_err[1]); end
        step(0, 0, 0, 1, 3);
        checks++; if (o_rd_valid[0] !== 1'b1 || o_rd_data[0] !== 4'h9) begin failures++; $display("FAIL esim_pop got=%b/%h exp=1/9", o_rd_valid[0], o_rd_data[0]); end
    endtask

    task automatic test_interleave();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) step(1, 0, 4'($urandom), 1, 1);
            else step(1, 1, 4'($urandom), 1, 0);
            for (int k = 0; k < 2; k++) begin
                checks++; if (o_rd_valid[k] !== m_rd_valid[k] || o_rd_data[k] !== m_rd_data[k]) begin failures++; $display("FAIL ilv_pop k%0d c%0d got=%b/%h exp=%b/%h", k, i, o_rd_valid[k], o_rd_data[k], m_rd_valid[k], m_rd_data[k]); end
                checks++; if (o_count[k] !== m_count(k)) begin failures++; $display("FAIL ilv_count k%0d c%0d got=%h exp=%h", k, i, o_count[k], m_count(k)); end
            end
        end
        step(1, 3, 4'h5, 0, 0);
        checks++; if (o_err[1][0] !== 1'b1) begin failures++; $display("FAIL ilv_err_ch got=%b exp=1", o_err[1][0]); end
        checks++; if (o_count[1] !== m_count(1)) begin failures++; $display("FAIL ilv_ch3_ignored got=%h exp=%h", o_count[1], m_count(1)); end
        checks++; if (o_count[0] !== m_count(0)) begin failures++; $display("FAIL ilv_ch3_dut4 got=%h exp=%h", o_count[0], m_count(0)); end
        step(1, 0, 4'h7, 0, 0);
        rst = 1'b1;
        step(0, 0, 0, 1, 0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (o_rd_valid[k] !== 1'b0) begin failures++; $display("FAIL rst_pop_valid k%0d got=%b exp=0", k, o_rd_valid[k]); end
            checks++; if (o_count[k] !== 12'h0) begin failures++; $display("FAIL rst_pop_count k%0d got=%h exp=0", k, o_count[k]); end
            checks++; if (o_err[k] !== 3'b000) begin failures++; $display("FAIL rst_pop_err k%0d got=%b exp=000", k, o_err[k]); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            rst = $urandom_range(0, 59) == 0;
            step(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom), 2'($urandom));
            for (int k = 0; k < 2; k++) begin
                checks++; if (o_rd_valid[k] !== m_rd_valid[k] || o_rd_data[k] !== m_rd_data[k]) begin failures++; $display("FAIL rnd_pop k%0d c%0d got=%b/%h exp=%b/%h", k, i, o_rd_valid[k], o_rd_data[k], m_rd_valid[k], m_rd_data[k]); end
                checks++; if (o_full[k] !== m_full(k) || o_empty[k] !== m_empty(k)) begin failures++; $display("FAIL rnd_flags k%0d c%0d got=%h/%h exp=%h/%h", k, i, o_full[k], o_empty[k], m_full(k), m_empty(k)); end
                checks++; if (o_count[k] !== m_count(k)) begin failures++; $display("FAIL rnd_count k%0d c%0d got=%h exp=%h", k, i, o_count[k], m_count(k)); end
                checks++; if (o_err[k] !== m_err[k]) begin failures++; $display("FAIL rnd_err k%0d c%0d got=%b exp=%b", k, i, o_err[k], m_err[k]); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_overflow();
        test_full_simul();
        test_empty_simul();
        test_interleave();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vc_idx_fifo.md
Name: vc_idx_fifo

Overview:
Multi-channel successor to the single FIFO index map used in the custom router. It holds NUM_CH independent circular FIFOs, one per virtual channel, each DEPTH entries of WIDTH bits. Each FIFO keeps its own pointers, occupancy, full/empty status and sticky error flags. Read data is registered. The router input stage pushes buffer-slot indices per channel, and the switch allocator pops them.

Parameters:
NUM_CH, 4, number of channels; must be >= 2
CH_SZ, 2, channel select width; 2**CH_SZ >= NUM_CH
DEPTH, 3, entries per channel; any value >= 2, power of two not required
PTR_SZ, 2, pointer width; 2**PTR_SZ >= DEPTH
WIDTH, 4, entry width in bits

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  push request
wr_ch  in  CH_SZ  push channel
wr_data  in  WIDTH  push data
rd_en  in  1  pop request
rd_ch  in  CH_SZ  pop channel
rd_data  out  WIDTH  registered pop data
rd_valid  out  1  high one cycle after an accepted pop
full  out  NUM_CH  per-channel full, bit i = channel i
empty  out  NUM_CH  per-channel empty
count  out  NUM_CH*(PTR_SZ+1)  per-channel occupancy; channel i at bits [i*(PTR_SZ+1) +: PTR_SZ+1]
err_ovf  out  1  sticky: push rejected because the channel was full
err_udf  out  1  sticky: pop rejected because the channel was empty
err_ch  out  1  sticky: wr_ch or rd_ch >= NUM_CH while its enable was high

Behaviour:
- Reset when rst=1 at a clock edge:
  - all wptr, rptr and count = 0; empty = all 1s; full = 0
  - rd_valid = 0; rd_data = 0; err_ovf, err_udf, err_ch = 0
  - storage array is not reset
  - rst has priority over wr_en and rd_en in the same cycle; any in-flight pop is discarded (rd_valid = 0 next cycle)
- full[i] = (count_i == DEPTH); empty[i] = (count_i == 0). Both are driven combinationally from registered counts.
- Accept decisions use pre-edge state:
  - pop_ok = rd_en & (rd_ch < NUM_CH) & !empty[rd_ch]
  - push_ok = wr_en & (wr_ch < NUM_CH) & (!full[wr_ch] | (pop_ok & rd_ch == wr_ch))
- Accepted push: mem[wr_ch][wptr] <= wr_data; wptr advances.
- Accepted pop: rd_data <= mem[rd_ch][rptr]; rd_valid <= 1; rptr advances.
- Without an accepted pop: rd_valid <= 0 and rd_data holds its value.
- Pointer wrap: the next pointer is 0 when the pointer equals DEPTH-1, else pointer+1. Wrap is explicit because DEPTH need not be a power of two.
- Pop latency: 1 cycle (data on rd_data with rd_valid in the cycle after the request).
- Push-to-pop: an entry pushed at edge N is poppable from the cycle after N. There is no same-cycle bypass.
- count update per channel:
  - +1 on push_ok only
  - -1 on pop_ok only
  - unchanged when both hit the same channel
  - on different channels, each channel is updated independently
- Simultaneous push and pop, same channel:
  - if full: both accepted, count stays DEPTH, pop returns the oldest entry
  - if empty: pop rejected and err_udf set; push accepted, count = 1
- Rejected push on a full channel (no same-channel pop): data dropped, pointers unchanged, err_ovf <= 1.
- Rejected pop on an empty channel: rd_valid = 0 next cycle, err_udf <= 1.
- Channel out of range (>= NUM_CH) with its enable high: the operation is ignored and err_ch <= 1. The other operation in the same cycle proceeds normally.
- Error flags stay set until rst.
- Channels are fully independent. Operations on one channel never affect another channel's pointers, count or data.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: empty=4'b1111, full=0, count=0, rd_valid=0, rd_data=0, all err=0.
- Per-channel ordering:
  - Stimulus: push 4'h1, 4'h2, 4'h3 to ch2; then pop ch2 three times.
  - Required: full[2]=1 after the 3rd push; rd_data 1,2,3, each with rd_valid one cycle after its rd_en; empty[2]=1 at the end; ch0/1/3 counts remain 0.
- Overflow and wrap:
  - Stimulus: fill ch1 with A,B,C; push D; pop one; push E; pop three.
  - Required: D dropped and err_ovf=1; pops return A, then B,C,E (wptr wrapped 2->0).
- Simultaneous push/pop on a full channel:
  - Stimulus: ch0 holds 5,6,7; same cycle wr ch0=8 and rd ch0.
  - Required: rd_data=5, count0 stays 3, err_ovf=0; subsequent pops return 6,7,8.
- Pop from an empty channel with a concurrent push:
  - Stimulus: ch3 empty; same cycle wr ch3=9 and rd ch3.
  - Required: rd_valid=0, err_udf=1, count3=1; the next pop returns 9.
- Interleave and reset mid-operation:
  - Stimulus: alternate pushes ch0/ch1 each cycle with a pop of the other channel; with NUM_CH=3, wr_ch=3; assert rst in the same cycle as an accepted pop.
  - Required: data per channel stays in order with no cross-channel corruption; err_ch=1 and the wr_ch=3 push is ignored; after rst, rd_valid=0, all counts=0, all flags cleared.
